// File: rtl/aurora_link_pkg.sv
// Shared encodings for the Aurora link supervisor.
// Latency: n/a (constants only).
// Backpressure: n/a.
package aurora_link_pkg;

   localparam int ST_W  = 3;
   localparam int TMR_W = 20;

   localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [ST_W-1:0] ST_WAIT_PLL = 3'd1;
   localparam logic [ST_W-1:0] ST_RESET    = 3'd2;
   localparam logic [ST_W-1:0] ST_WAIT_UP  = 3'd3;
   localparam logic [ST_W-1:0] ST_STABLE   = 3'd4;
   localparam logic [ST_W-1:0] ST_LINK_UP  = 3'd5;
   localparam logic [ST_W-1:0] ST_FAULT    = 3'd6;

endpackage

// File: rtl/aurora_sync_bit.sv
// Two-flop synchroniser for one asynchronous status bit.
// Latency: 2 clk cycles.
// Backpressure: none; samples every cycle.
module aurora_sync_bit #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture; the first stage may go metastable, the second settles it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/aurora_link_supervisor.sv
// Bring-up / recovery sequencer for one 2-lane Aurora 64B/66B channel.
// Latency: 2-cycle input sync + 1 cycle decision; all outputs registered.
// Backpressure: none; status inputs are sampled every init_clk cycle.
module aurora_link_supervisor
   import aurora_link_pkg::*;
#(
   parameter int RST_HOLD_CYC    = 128,
   parameter int UP_TIMEOUT_CYC  = 1000000,
   parameter int STABLE_CYC      = 10000,
   parameter int SOFT_ERR_WIN    = 65536,
   parameter int SOFT_ERR_THRESH = 16,
   parameter int MAX_RETRY       = 8
) (
   input  logic        init_clk,
   input  logic        system_rst,
   input  logic        link_en,
   input  logic        gt_qplllock,
   input  logic        channel_up,
   input  logic        hard_err,
   input  logic        soft_err,
   output logic        aurora_rst,
   output logic        link_ok,
   output logic        link_fault,
   output logic [2:0]  sup_state,
   output logic [3:0]  retry_cnt,
   output logic [15:0] relink_cnt
);

   localparam int WIN_W = (SOFT_ERR_WIN > 1) ? $clog2(SOFT_ERR_WIN) : 1;
   localparam int CNT_W = $clog2(SOFT_ERR_THRESH + 1);

   localparam logic [TMR_W-1:0] LD_RST    = TMR_W'(RST_HOLD_CYC - 1);
   localparam logic [TMR_W-1:0] LD_UP     = TMR_W'(UP_TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] LD_STABLE = TMR_W'(STABLE_CYC - 1);
   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(SOFT_ERR_WIN - 1);
   localparam logic [CNT_W-1:0] THRESH    = CNT_W'(SOFT_ERR_THRESH);
   localparam logic [3:0]       MAX_R     = 4'(MAX_RETRY);

   // Timer loads must fit the 20-bit down-counter; retry budget must fit retry_cnt.
   if (RST_HOLD_CYC > (1 << TMR_W) || UP_TIMEOUT_CYC > (1 << TMR_W) ||
       STABLE_CYC > (1 << TMR_W) || RST_HOLD_CYC < 2 || MAX_RETRY > 15) begin : g_param_err
      $error("aurora_link_supervisor: parameter out of range");
   end

   logic lock_s, up_s, herr_s, serr_s;

   aurora_sync_bit #(.RST_VAL(1'b0)) u_sync_lock (.clk_i(init_clk), .rst_i(system_rst), .d_i(gt_qplllock), .q_o(lock_s));
   aurora_sync_bit #(.RST_VAL(1'b0)) u_sync_up   (.clk_i(init_clk), .rst_i(system_rst), .d_i(channel_up),  .q_o(up_s));
   aurora_sync_bit #(.RST_VAL(1'b0)) u_sync_herr (.clk_i(init_clk), .rst_i(system_rst), .d_i(hard_err),    .q_o(herr_s));
   aurora_sync_bit #(.RST_VAL(1'b0)) u_sync_serr (.clk_i(init_clk), .rst_i(system_rst), .d_i(soft_err),    .q_o(serr_s));

   logic [ST_W-1:0]  state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [3:0]       retry_q, retry_d;
   logic [15:0]      relink_q, relink_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] serr_q, serr_d;
   logic             aurora_rst_q, link_ok_q, link_fault_q;

   logic [3:0]       retry_inc;
   logic [15:0]      relink_inc;
   logic [CNT_W-1:0] serr_nxt;
   logic             fail;

   assign retry_inc  = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
   assign relink_inc = (relink_q == 16'hFFFF) ? relink_q : relink_q + 16'd1;
   assign serr_nxt   = serr_q + CNT_W'(serr_s);

   // Next-state, timer and counter logic; priority follows the if/else order.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      retry_d  = retry_q;
      relink_d = relink_q;
      win_d    = win_q;
      serr_d   = serr_q;
      fail     = 1'b0;

      if (!link_en) begin
         state_d = ST_IDLE;
         retry_d = 4'd0;
      end else if (!lock_s && (state_q == ST_RESET || state_q == ST_WAIT_UP ||
                               state_q == ST_STABLE || state_q == ST_LINK_UP)) begin
         state_d = ST_WAIT_PLL;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_WAIT_PLL;
            ST_WAIT_PLL: begin
               if (lock_s) begin
                  state_d = ST_RESET;
                  timer_d = LD_RST;
               end
            end
            ST_RESET: begin
               if (timer_q == '0) begin
                  state_d = ST_WAIT_UP;
                  timer_d = LD_UP;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_WAIT_UP: begin
               if (up_s) begin
                  state_d = ST_STABLE;
                  timer_d = LD_STABLE;
               end else if (timer_q == '0) begin
                  fail = 1'b1;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_STABLE: begin
               if (herr_s || !up_s) begin
                  fail = 1'b1;
               end else if (timer_q == '0) begin
                  state_d = ST_LINK_UP;
                  retry_d = 4'd0;
                  win_d   = '0;
                  serr_d  = '0;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_LINK_UP: begin
               // Threshold is checked before the window wrap so a hit on the
               // last cycle of a window still counts.
               if (herr_s || !up_s || serr_nxt >= THRESH) begin
                  fail     = 1'b1;
                  relink_d = relink_inc;
               end else if (win_q == WIN_LAST) begin
                  win_d  = '0;
                  serr_d = '0;
               end else begin
                  win_d  = win_q + 1'b1;
                  serr_d = serr_nxt;
               end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
         endcase

         if (fail) begin
            retry_d = retry_inc;
            if (MAX_RETRY != 0 && retry_inc >= MAX_R) begin
               state_d = ST_FAULT;
            end else begin
               state_d = ST_RESET;
               timer_d = LD_RST;
            end
         end
      end
   end

   // State and counter registers; outputs are decoded from the next state so they align with sup_state.
   always_ff @(posedge init_clk or posedge system_rst) begin
      if (system_rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         retry_q      <= 4'd0;
         relink_q     <= 16'd0;
         win_q        <= '0;
         serr_q       <= '0;
         aurora_rst_q <= 1'b1;
         link_ok_q    <= 1'b0;
         link_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         retry_q      <= retry_d;
         relink_q     <= relink_d;
         win_q        <= win_d;
         serr_q       <= serr_d;
         aurora_rst_q <= !(state_d == ST_WAIT_UP || state_d == ST_STABLE || state_d == ST_LINK_UP);
         link_ok_q    <= (state_d == ST_LINK_UP);
         link_fault_q <= (state_d == ST_FAULT);
      end
   end

   assign aurora_rst = aurora_rst_q;
   assign link_ok    = link_ok_q;
   assign link_fault = link_fault_q;
   assign sup_state  = state_q;
   assign retry_cnt  = retry_q;
   assign relink_cnt = relink_q;

endmodule

// File: doc/aurora_link_supervisor.md
Name: aurora_link_supervisor

Overview:
- Sequences bring-up and recovery of one 2-lane Aurora 64B/66B channel.
- Holds the channel reset (drives the channel's system_rst) until the shared QPLL locks, waits for channel_up with a timeout, and qualifies link stability.
- Re-initialises the channel on timeout, link drop, hard error or soft-error bursts, and latches a fault after repeated failures.
- Runs in the init_clk domain, between board-level control/status and the channel wrapper.

Parameters:
- RST_HOLD_CYC, 128: init_clk cycles aurora_rst is held per reset attempt (≥2).
- UP_TIMEOUT_CYC, 1000000: cycles allowed from reset release to channel_up (10 ms at 100 MHz).
- STABLE_CYC, 10000: cycles channel_up must stay high before link_ok asserts.
- SOFT_ERR_WIN, 65536: soft-error observation window, in cycles.
- SOFT_ERR_THRESH, 16: soft-error-high cycles within one window that trigger a retry.
- MAX_RETRY, 8: consecutive failed attempts before FAULT; 0 means retry forever.

Ports:
- init_clk in 1: supervisor clock, 100 MHz.
- system_rst in 1: asynchronous, active-high reset.
- link_en in 1: enables bring-up; already in the init_clk domain.
- gt_qplllock in 1: QPLL lock; asynchronous, synchronised internally.
- channel_up in 1: channel status, user_clk domain; synchronised internally.
- hard_err in 1: user_clk domain; synchronised internally.
- soft_err in 1: user_clk domain; synchronised internally.
- aurora_rst out 1: reset to the channel wrapper's system_rst.
- link_ok out 1: link qualified and usable.
- link_fault out 1: retry budget exhausted.
- sup_state out 3: current state code.
- retry_cnt out 4: consecutive failed attempts, saturating.
- relink_cnt out 16: total re-initialisations since reset, saturating at 0xFFFF.

Behaviour:
- Reset state: sup_state=IDLE(0), aurora_rst=1, link_ok=0, link_fault=0, retry_cnt=0, relink_cnt=0, all timers 0.
- Synchronisers: all async inputs pass through 2-flop synchronisers (2-cycle latency). All decisions use the synchronised values only.
- Outputs: all registered. aurora_rst=1 in every state except WAIT_UP, STABLE and LINK_UP. link_ok=1 only in LINK_UP. link_fault=1 only in FAULT.
- State codes: IDLE=0, WAIT_PLL=1, RESET=2, WAIT_UP=3, STABLE=4, LINK_UP=5, FAULT=6.
- IDLE: link_en=1 → WAIT_PLL.
- WAIT_PLL: lock=1 → RESET; load timer=RST_HOLD_CYC-1.
- RESET: timer decrements. At 0 → WAIT_UP; load timer=UP_TIMEOUT_CYC-1.
- WAIT_UP:
  - chan_up=1 → STABLE; load timer=STABLE_CYC-1.
  - timer reaches 0 with chan_up=0 → RETRY path.
- STABLE:
  - chan_up=0 or hard_err=1 → RETRY path.
  - timer reaches 0 → LINK_UP; clear retry_cnt.
- LINK_UP:
  - chan_up=0 or hard_err=1 → RETRY path.
  - soft-error count reaches SOFT_ERR_THRESH within the current window → RETRY path.
  - Window counter free-runs in LINK_UP. Soft-error count resets at window wrap and on LINK_UP entry.
  - Window wrap and threshold hit in the same cycle: threshold wins.
- RETRY path (same cycle):
  - retry_cnt+1 (saturating at 15); relink_cnt+1 if the failure occurred in LINK_UP.
  - If MAX_RETRY≠0 and the new retry_cnt ≥ MAX_RETRY → FAULT; else → RESET, reload RST_HOLD_CYC-1.
- FAULT: sticky. Left only via link_en=0 → IDLE.
- Global overrides, in priority order, highest first:
  1. link_en=0 in any state → IDLE, aurora_rst=1, retry_cnt=0.
  2. lock=0 in RESET/WAIT_UP/STABLE/LINK_UP → WAIT_PLL. Not counted as a retry.
  3. hard_err.
  4. chan_up loss.
  5. soft-error threshold.
  6. Timer expiry.
- Counters: retry_cnt and relink_cnt survive link_en toggles except as stated in override 1; relink_cnt is never cleared except by system_rst.
- Timer: 20-bit down-counter, sized for the largest of RST_HOLD_CYC, UP_TIMEOUT_CYC, STABLE_CYC. Elaboration error if any of these exceeds 2^20.
- system_rst mid-operation: immediate return to the reset state; aurora_rst asserts asynchronously.

Decomposition:
- Shared package aurora_link_pkg: state encodings (IDLE..FAULT), the 3-bit state width, and the 20-bit timer width.
- Sub-module aurora_sync_bit: parameterisable 2-flop synchroniser with async reset value. Instantiated for lock, chan_up, hard_err and soft_err (reset value 0).

Test Plan:
(Bench parameters: RST_HOLD_CYC=8, UP_TIMEOUT_CYC=100, STABLE_CYC=20, SOFT_ERR_WIN=64, SOFT_ERR_THRESH=4, MAX_RETRY=3.)
- Nominal bring-up: link_en=1, lock=1, channel_up rises 30 cycles after aurora_rst falls → aurora_rst low exactly 8 cycles after entering RESET; link_ok=1 at 20 cycles + 2-cycle sync after channel_up; retry_cnt=0.
- Timeout to fault: channel_up held 0 → three 100-cycle WAIT_UP windows, each preceded by an 8-cycle reset; link_fault=1 and sup_state=6 with retry_cnt=3; link_en=0 → IDLE, retry_cnt=0.
- Link drop in LINK_UP: channel_up falls for 1 cycle → link_ok=0 and aurora_rst=1 within 3 cycles; relink_cnt=1, retry_cnt=1; re-qualifies to LINK_UP with retry_cnt=0.
- Soft-error burst: 4 soft_err-high cycles inside one 64-cycle window → retry; 3 cycles per window over 5 windows → no retry.
- PLL loss plus hard_err in the same cycle during STABLE → WAIT_PLL, retry_cnt unchanged; lock restored → RESET.
- system_rst pulse while in LINK_UP → all outputs return to reset values, including relink_cnt=0.
